// File: rtl/data_mem_arbiter.sv
// Single-port data RAM arbiter between the CPU Memory stage and a host burst
// port. Host bursts take priority, but a requesting CPU is never starved.
module data_mem_arbiter #(
   parameter int MAX_CPU_STALL = 4,
   parameter int LEN_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [15:0]      cpu_addr,
   input  logic [15:0]      cpu_wdata,
   output logic [15:0]      cpu_rdata,
   output logic             cpu_stall,
   input  logic             host_start,
   input  logic             host_we,
   input  logic [15:0]      host_base,
   input  logic [LEN_W-1:0] host_len,
   input  logic [15:0]      host_wdata,
   input  logic             host_wvalid,
   output logic             host_wready,
   output logic [15:0]      host_rdata,
   output logic             host_rvalid,
   output logic             host_busy,
   output logic             host_done,
   output logic [15:0]      ram_address,
   output logic [15:0]      ram_data,
   output logic             ram_wren,
   input  logic [15:0]      ram_q
);
   localparam int SC_W = (MAX_CPU_STALL < 1) ? 1 : $clog2(MAX_CPU_STALL + 1);
   localparam logic [SC_W-1:0] STALL_LIMIT = SC_W'(MAX_CPU_STALL);

   typedef enum logic {IDLE, BURST} state_e;

   state_e           state_q;
   logic [15:0]      addr_cnt_q;
   logic [LEN_W-1:0] beats_left_q;
   logic             dir_we_q;
   logic [SC_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic             rd_pending_q, rd_owner_host_q;
   logic             host_done_q;

   logic in_burst, forced_grant, host_beat, cpu_grant;

   // While reset is held low nobody is granted, so no stray write reaches the RAM.
   always_comb begin
      in_burst     = reset && (state_q == BURST);
      forced_grant = in_burst && cpu_req && (stall_cnt_q == STALL_LIMIT);
      host_beat    = in_burst && !forced_grant && (!dir_we_q || host_wvalid);
      cpu_grant    = reset && cpu_req && !host_beat;
   end

   assign cpu_stall   = reset && cpu_req && !cpu_grant;
   assign host_wready = host_beat && dir_we_q;
   assign ram_address = host_beat ? addr_cnt_q : cpu_addr;
   assign ram_data    = host_beat ? host_wdata : cpu_wdata;
   assign ram_wren    = host_beat ? dir_we_q : (cpu_grant && cpu_we);
   assign host_busy   = (state_q == BURST);
   assign host_done   = host_done_q;
   assign host_rvalid = rd_pending_q && rd_owner_host_q;
   assign host_rdata  = host_rvalid ? ram_q : 16'h0000;
   assign cpu_rdata   = ram_q;

   always_comb begin
      stall_cnt_d = '0;
      if (cpu_stall) stall_cnt_d = stall_cnt_q + SC_W'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= IDLE;
         addr_cnt_q      <= '0;
         beats_left_q    <= '0;
         dir_we_q        <= 1'b0;
         stall_cnt_q     <= '0;
         rd_pending_q    <= 1'b0;
         rd_owner_host_q <= 1'b0;
         host_done_q     <= 1'b0;
      end else begin
         host_done_q     <= 1'b0;
         stall_cnt_q     <= stall_cnt_d;
         rd_pending_q    <= (host_beat && !dir_we_q) || (cpu_grant && !cpu_we);
         rd_owner_host_q <= host_beat;
         case (state_q)
            IDLE: begin
               if (host_start) begin
                  addr_cnt_q   <= host_base;
                  beats_left_q <= host_len;
                  dir_we_q     <= host_we;
                  if (host_len != '0) state_q <= BURST;
                  else                host_done_q <= 1'b1;
               end
            end
            BURST: begin
               if (host_beat) begin
                  addr_cnt_q   <= addr_cnt_q + 16'd1;
                  beats_left_q <= beats_left_q - LEN_W'(1);
                  if (beats_left_q == LEN_W'(1)) begin
                     state_q     <= IDLE;
                     host_done_q <= 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised bench for data_mem_arbiter: a behavioural RAM plus a shadow copy
// of its expected contents, with burst/grant expectations derived per cycle.
module tb_data_mem_arbiter;
   localparam int MAX = 4;
   localparam int LW  = 8;

   logic clk = 1'b0;
   logic reset;
   logic cpu_req, cpu_we, cpu_stall;
   logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic host_start, host_we, host_wvalid, host_wready, host_rvalid, host_busy, host_done;
   logic [15:0] host_base, host_wdata, host_rdata;
   logic [LW-1:0] host_len;
   logic [15:0] ram_address, ram_data, ram_q;
   logic ram_wren;

   logic [15:0] ram   [0:65535];
   logic [15:0] model [0:65535];
   logic [15:0] salt;
   logic preload;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_arbiter #(.MAX_CPU_STALL(MAX), .LEN_W(LW)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .host_start(host_start), .host_we(host_we), .host_base(host_base), .host_len(host_len),
      .host_wdata(host_wdata), .host_wvalid(host_wvalid), .host_wready(host_wready),
      .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_busy(host_busy),
      .host_done(host_done),
      .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
   );

   function automatic logic [15:0] init_val(input int a);
      return 16'(a * 40503) ^ salt;
   endfunction

   // Synchronous RAM, read-before-write, one-cycle read latency.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 65536; i++) ram[i] <= init_val(i);
      end else if (ram_wren) begin
         ram[ram_address] <= ram_data;
      end
      ram_q <= ram[ram_address];
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      host_start = 1'b0; host_we = 1'b0; host_base = '0; host_len = '0;
      host_wdata = '0; host_wvalid = 1'b0;
   endtask

   task automatic test_reset();
      quiet();
      reset = 1'b0; preload = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
         cyc();
         checks++; if (host_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", host_busy); end
         checks++; if (host_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", host_done); end
         checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", host_rvalid); end
         checks++; if (host_wready !== 1'b0) begin errors++; $display("FAIL reset_wready got %b want 0", host_wready); end
         checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", ram_wren); end
         checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", cpu_stall); end
         checks++; if (host_rdata !== 16'h0000) begin errors++; $display("FAIL reset_rdata got %h want 0000", host_rdata); end
         checks++; if (ram_address !== cpu_addr) begin errors++; $display("FAIL reset_addr got %h want %h", ram_address, cpu_addr); end
      end
      preload = 1'b0;
      quiet();
      reset = 1'b1;
      cyc();
   endtask

   task automatic test_idle_cpu();
      logic [15:0] a, d;
      for (int i = 0; i < 6; i++) begin
         a = (i == 0) ? 16'h0010 : 16'($urandom);
         d = (i == 0) ? 16'h1234 : 16'($urandom);
         cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
         #1;
         checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL idle_st_stall got %b want 0", cpu_stall); end
         checks++; if (ram_wren !== 1'b1 || ram_address !== a || ram_data !== d) begin
            errors++; $display("FAIL idle_store got wren=%b addr=%h data=%h want 1 %h %h", ram_wren, ram_address, ram_data, a, d); end
         model[a] = d;
         cyc();
         cpu_we = 1'b0;
         #1;
         checks++; if (cpu_stall !== 1'b0 || ram_wren !== 1'b0) begin
            errors++; $display("FAIL idle_load got stall=%b wren=%b want 0 0", cpu_stall, ram_wren); end
         cyc();
         cpu_req = 1'b0;
         #1;
         checks++; if (cpu_rdata !== model[a]) begin errors++; $display("FAIL idle_rdata got %h want %h", cpu_rdata, model[a]); end
         cyc();
      end
   endtask

   task automatic do_write_burst(input logic [15:0] base, input int len, input int gap_at, input bit poke);
      int beat, gaps;
      logic [15:0] exp_addr;
      logic [15:0] touched[$];
      beat = 0; gaps = 0;
      quiet();
      host_start = 1'b1; host_we = 1'b1; host_base = base; host_len = LW'(len);
      #1;
      checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL wr_start_wren got %b want 0", ram_wren); end
      cyc();
      host_start = 1'b0;
      for (int c = 0; c < 4 * len + 8 && beat < len; c++) begin
         exp_addr = base + 16'(beat);
         if (gap_at == beat && gaps < 2) begin
            host_wvalid = 1'b0; host_start = 1'b0;
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
            #1;
            checks++; if (cpu_stall !== 1'b0 || host_wready !== 1'b0) begin
               errors++; $display("FAIL gap_grant got stall=%b wready=%b want 0 0", cpu_stall, host_wready); end
            checks++; if (ram_wren !== 1'b1 || ram_address !== cpu_addr || ram_data !== cpu_wdata) begin
               errors++; $display("FAIL gap_store got wren=%b addr=%h data=%h want 1 %h %h", ram_wren, ram_address, ram_data, cpu_addr, cpu_wdata); end
            model[cpu_addr] = cpu_wdata;
            touched.push_back(cpu_addr);
            gaps++;
         end else begin
            cpu_req = 1'b0; cpu_we = 1'b0;
            host_wvalid = 1'b1; host_wdata = 16'($urandom);
            host_start = poke && (beat == 1);
            host_we = !(poke && (beat == 1));
            host_base = 16'($urandom); host_len = LW'($urandom_range(1, 255));
            #1;
            checks++; if (host_wready !== 1'b1) begin errors++; $display("FAIL wr_wready got %b want 1", host_wready); end
            checks++; if (ram_wren !== 1'b1 || ram_address !== exp_addr || ram_data !== host_wdata) begin
               errors++; $display("FAIL wr_beat got wren=%b addr=%h data=%h want 1 %h %h", ram_wren, ram_address, ram_data, exp_addr, host_wdata); end
            checks++; if (host_busy !== 1'b1 || host_done !== 1'b0) begin
               errors++; $display("FAIL wr_flags got busy=%b done=%b want 1 0", host_busy, host_done); end
            model[exp_addr] = host_wdata;
            touched.push_back(exp_addr);
            beat++;
         end
         cyc();
      end
      quiet();
      #1;
      checks++; if (host_done !== 1'b1 || host_busy !== 1'b0) begin
         errors++; $display("FAIL wr_done got done=%b busy=%b want 1 0", host_done, host_busy); end
      checks++; if (host_wready !== 1'b0) begin errors++; $display("FAIL wr_after_wready got %b want 0", host_wready); end
      cyc();
      checks++; if (host_done !== 1'b0) begin errors++; $display("FAIL wr_done_once got %b want 0", host_done); end
      foreach (touched[i]) begin
         checks++; if (ram[touched[i]] !== model[touched[i]]) begin
            errors++; $display("FAIL wr_mem[%h] got %h want %h", touched[i], ram[touched[i]], model[touched[i]]); end
      end
   endtask

   task automatic do_read_burst(input logic [15:0] base, input int len, input bit cpu_on);
      bit hbeat, prev_hbeat, prev_crd, finished;
      logic [15:0] haddr, prev_haddr, prev_caddr;
      int beat;
      beat = 0; prev_hbeat = 1'b0; finished = 1'b0; prev_haddr = '0;
      quiet();
      host_start = 1'b1; host_we = 1'b0; host_base = base; host_len = LW'(len);
      cpu_req = cpu_on; cpu_addr = 16'($urandom);
      #1;
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL start_cpu_stall got %b want 0", cpu_stall); end
      prev_crd = cpu_on; prev_caddr = cpu_addr;
      cyc();
      host_start = 1'b0;
      for (int k = 0; k < 8 * len + 16 && !finished; k++) begin
         if (prev_crd) cpu_addr = 16'($urandom);
         // A held CPU request wins exactly every (MAX+1)-th cycle of a full-rate burst.
         hbeat = (beat < len) && !(cpu_on && (k % (MAX + 1)) == MAX);
         haddr = base + 16'(beat);
         #1;
         checks++; if (host_rvalid !== prev_hbeat) begin errors++; $display("FAIL rd_rvalid got %b want %b", host_rvalid, prev_hbeat); end
         if (prev_hbeat) begin
            checks++; if (host_rdata !== model[prev_haddr]) begin
               errors++; $display("FAIL rd_data[%h] got %h want %h", prev_haddr, host_rdata, model[prev_haddr]); end
         end
         if (prev_crd) begin
            checks++; if (cpu_rdata !== model[prev_caddr]) begin
               errors++; $display("FAIL cpu_load[%h] got %h want %h", prev_caddr, cpu_rdata, model[prev_caddr]); end
         end
         checks++; if (host_done !== (prev_hbeat && beat == len)) begin
            errors++; $display("FAIL rd_done got %b want %b", host_done, prev_hbeat && beat == len); end
         checks++; if (host_busy !== (beat < len)) begin errors++; $display("FAIL rd_busy got %b want %b", host_busy, beat < len); end
         checks++; if (cpu_stall !== (cpu_on && hbeat)) begin
            errors++; $display("FAIL rd_stall k=%0d got %b want %b", k, cpu_stall, cpu_on && hbeat); end
         if (hbeat) begin
            checks++; if (ram_address !== haddr || ram_wren !== 1'b0) begin
               errors++; $display("FAIL rd_issue got addr=%h wren=%b want %h 0", ram_address, ram_wren, haddr); end
         end
         if (beat == len && !hbeat) finished = 1'b1;
         prev_crd = cpu_on && !hbeat; prev_caddr = cpu_addr;
         prev_hbeat = hbeat; prev_haddr = haddr;
         if (hbeat) beat++;
         cyc();
      end
      quiet();
   endtask

   task automatic test_write_burst();
      do_write_burst(16'h0100, 4, -1, 1'b0);
   endtask

   task automatic test_forced_grant();
      do_read_burst(16'($urandom), 16, 1'b1);
      do_read_burst(16'($urandom), $urandom_range(3, 12), 1'b1);
      do_read_burst(16'($urandom), $urandom_range(1, 6), 1'b0);
   endtask

   task automatic test_wrap_zero();
      do_write_burst(16'hFFFE, 3, -1, 1'b0);
      quiet();
      host_start = 1'b1; host_we = 1'($urandom); host_base = 16'($urandom); host_len = '0;
      #1;
      checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL zero_start_wren got %b want 0", ram_wren); end
      cyc();
      host_start = 1'b0;
      #1;
      checks++; if (host_done !== 1'b1 || host_busy !== 1'b0) begin
         errors++; $display("FAIL zero_done got done=%b busy=%b want 1 0", host_done, host_busy); end
      checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL zero_wren got %b want 0", ram_wren); end
      cyc();
      checks++; if (host_done !== 1'b0) begin errors++; $display("FAIL zero_done_once got %b want 0", host_done); end
   endtask

   task automatic test_write_gaps();
      do_write_burst(16'($urandom), 6, 2, 1'b0);
      do_write_burst(16'($urandom), 5, $urandom_range(1, 4), 1'b0);
   endtask

   task automatic test_back_to_back();
      logic [15:0] b;
      int n;
      b = 16'($urandom);
      n = $urandom_range(2, 9);
      do_write_burst(b, n, -1, 1'b1);
      do_read_burst(b, n, 1'b1);
   endtask

   task automatic test_reset_mid_burst();
      quiet();
      host_start = 1'b1; host_we = 1'b0; host_base = 16'($urandom); host_len = LW'(8);
      cyc();
      host_start = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (host_busy !== 1'b0 || host_rvalid !== 1'b0 || host_done !== 1'b0) begin
            errors++; $display("FAIL mid_reset got busy=%b rvalid=%b done=%b want 0 0 0", host_busy, host_rvalid, host_done); end
         checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL mid_reset_wren got %b want 0", ram_wren); end
         cyc();
      end
      do_read_burst(16'($urandom), $urandom_range(1, 8), 1'b0);
      do_write_burst(16'($urandom), 3, -1, 1'b0);
   endtask

   initial begin
      salt = 16'($urandom);
      for (int i = 0; i < 65536; i++) model[i] = init_val(i);
      test_reset();
      test_idle_cpu();
      test_write_burst();
      test_forced_grant();
      test_wrap_zero();
      test_write_gaps();
      test_back_to_back();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
